reg_file: RTL and testbench

//   Integer register file of the single-cycle RV32 core; sits directly upstream of the ALU.
//   rs1_data drives ALU operand A and rs2_data drives operand B (after the immediate mux).
//   Two combinational read ports, one synchronous write port and a debug read port.

---
 rtl/reg_file_if.sv | 28 ++
 rtl/reg_file.sv | 112 +++++++++++
 tb/tb_reg_file.sv | 130 +++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Bus bundle for the integer register file: two read ports, one write port,
// a debug read port and the clear/drop status.
interface reg_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic              we;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              busy;
   logic              wr_dropped;

   modport master (
      output rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
      input  rs1_data, rs2_data, dbg_data, busy, wr_dropped
   );

   modport slave (
      input  rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
      output rs1_data, rs2_data, dbg_data, busy, wr_dropped
   );
endinterface

// File: rtl/reg_file.sv
// RV32 integer register file with a sequential self-clear after reset.
// Optional macro REGFILE_BYPASS_EN enables write-through forwarding to all read ports.
module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   reg_file_if.slave  bus
);
   // state | meaning
   // CLEAR | zeroing x1..x(NREGS-1) one per cycle; busy, reads 0, writes dropped
   // READY | normal operation
   localparam int NREGS = 2 ** ADDR_W;

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic              busy_q, busy_d;
   logic              wr_dropped_q, wr_dropped_d;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] wr_val;
   logic              fwd_ok;
   logic [DATA_W-1:0] regs_q [NREGS];

   always_comb begin
      state_d      = state_q;
      clr_idx_d    = clr_idx_q;
      busy_d       = busy_q;
      wr_dropped_d = 1'b0;
      wr_en        = 1'b0;
      wr_idx       = bus.rd_addr;
      wr_val       = bus.rd_data;
      case (state_q)
         CLEAR: begin
            wr_en        = 1'b1;
            wr_idx       = clr_idx_q;
            wr_val       = '0;
            clr_idx_d    = clr_idx_q + ADDR_W'(1);
            wr_dropped_d = bus.we;
            if (clr_idx_q == {ADDR_W{1'b1}}) begin
               state_d = READY;
               busy_d  = 1'b0;
            end
         end
         READY: begin
            wr_en = bus.we && (bus.rd_addr != '0);
         end
         default: begin
            state_d = CLEAR;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= CLEAR;
         clr_idx_q    <= ADDR_W'(1);
         busy_q       <= 1'b1;
         wr_dropped_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_idx_q    <= clr_idx_d;
         busy_q       <= busy_d;
         wr_dropped_q <= wr_dropped_d;
      end
   end

   // x0 is never written; its read is forced to zero below instead
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         regs_q[wr_idx] <= wr_val;
      end
   end

   assign fwd_ok = (state_q == READY) && bus.we && (bus.rd_addr != '0);

   always_comb begin
      bus.rs1_data = regs_q[bus.rs1_addr];
      if (busy_q || bus.rs1_addr == '0) bus.rs1_data = '0;
`ifdef REGFILE_BYPASS_EN
      else if (fwd_ok && bus.rd_addr == bus.rs1_addr) bus.rs1_data = bus.rd_data;
`endif
   end

   always_comb begin
      bus.rs2_data = regs_q[bus.rs2_addr];
      if (busy_q || bus.rs2_addr == '0) bus.rs2_data = '0;
`ifdef REGFILE_BYPASS_EN
      else if (fwd_ok && bus.rd_addr == bus.rs2_addr) bus.rs2_data = bus.rd_data;
`endif
   end

   always_comb begin
      bus.dbg_data = regs_q[bus.dbg_addr];
      if (busy_q || bus.dbg_addr == '0) bus.dbg_data = '0;
`ifdef REGFILE_BYPASS_EN
      else if (fwd_ok && bus.rd_addr == bus.dbg_addr) bus.dbg_data = bus.rd_data;
`endif
   end

`ifndef REGFILE_BYPASS_EN
   logic unused_fwd;
   assign unused_fwd = fwd_ok;
`endif

   assign bus.busy       = busy_q;
   assign bus.wr_dropped = wr_dropped_q;
endmodule

// File: tb/tb_reg_file.sv
// Randomized self-checking bench for reg_file against a behavioural model
// (register array plus a busy-cycle countdown).
module tb_reg_file;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int N  = 2 ** AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] mdl [N];
   int            busy_left = 0;
   logic          exp_drop = 1'b0;

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (busy_left > 0 || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (bus.we && bus.rd_addr == a) return bus.rd_data;
`endif
      return mdl[a];
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // check outputs mid-cycle, then advance the model on the rising edge
   task automatic step(input bit do_chk);
      @(negedge clk);
      if (do_chk) begin
         chk("rs1_data",   bus.rs1_data, exp_rd(bus.rs1_addr));
         chk("rs2_data",   bus.rs2_data, exp_rd(bus.rs2_addr));
         chk("dbg_data",   bus.dbg_data, exp_rd(bus.dbg_addr));
         chk("busy",       DW'(bus.busy), DW'(busy_left > 0));
         chk("wr_dropped", DW'(bus.wr_dropped), DW'(exp_drop));
      end
      @(posedge clk);
      if (rst) begin
         busy_left = N - 1;
         exp_drop  = 1'b0;
         for (int i = 0; i < N; i++) mdl[i] = '0;
      end else begin
         exp_drop = (busy_left > 0) && bus.we;
         if (busy_left > 0) busy_left--;
         else if (bus.we && bus.rd_addr != '0) mdl[bus.rd_addr] = bus.rd_data;
      end
      #1;
   endtask

   task automatic idle();
      bus.we = 1'b0;
      bus.rd_addr = '0;
      bus.rd_data = '0;
   endtask

   initial begin
      rst = 1'b1;
      bus.rs1_addr = '0; bus.rs2_addr = '0; bus.dbg_addr = '0;
      idle();
      step(0);
      step(1);
      rst = 1'b0;
      for (int i = 0; i < N + 2; i++) begin
         bus.rs1_addr = AW'(i); bus.rs2_addr = AW'(N - 1 - i); bus.dbg_addr = AW'(i + 3);
         step(1);
      end
      for (int i = 1; i < N; i++) begin
         bus.dbg_addr = AW'(i); bus.rs1_addr = AW'(i); bus.rs2_addr = AW'(i);
         step(1);
      end

      bus.we = 1'b1; bus.rd_addr = 5; bus.rd_data = 32'd11;
      bus.rs1_addr = 5; bus.rs2_addr = 1; step(1);
      idle(); bus.rs1_addr = 5; bus.rs2_addr = 5; bus.dbg_addr = 5; step(1);

      bus.we = 1'b1; bus.rd_addr = 0; bus.rd_data = 32'hFFFF_FFEC;
      bus.rs1_addr = 0; bus.rs2_addr = 0; bus.dbg_addr = 0; step(1);
      idle(); step(1);

      bus.we = 1'b1; bus.rd_addr = 3; bus.rd_data = 32'd12; step(1);
      bus.we = 1'b1; bus.rd_addr = 3; bus.rd_data = -32'sd12;
      bus.rs1_addr = 3; bus.rs2_addr = 3; bus.dbg_addr = 3; step(1);
      idle(); step(1);

      rst = 1'b1; step(1);
      rst = 1'b0;
      bus.we = 1'b1; bus.rd_addr = 7; bus.rd_data = 32'd15;
      bus.rs1_addr = 7; bus.dbg_addr = 7; step(1);
      idle();
      for (int i = 0; i < 8; i++) step(1);
      rst = 1'b1; step(1);
      rst = 1'b0;
      for (int i = 0; i < N + 2; i++) begin
         bus.rs2_addr = AW'(i); step(1);
      end
      for (int i = 1; i < N; i++) begin
         bus.dbg_addr = AW'(i); step(1);
      end

      for (int i = 0; i < 600; i++) begin
         rst          = ($urandom_range(0, 149) == 0);
         bus.we       = $urandom_range(0, 2) != 0;
         bus.rd_addr  = AW'($urandom_range(0, N - 1));
         bus.rd_data  = $urandom;
         bus.rs1_addr = ($urandom_range(0, 3) == 0) ? bus.rd_addr : AW'($urandom_range(0, N - 1));
         bus.rs2_addr = ($urandom_range(0, 3) == 0) ? bus.rs1_addr : AW'($urandom_range(0, N - 1));
         bus.dbg_addr = ($urandom_range(0, 3) == 0) ? bus.rd_addr : AW'($urandom_range(0, N - 1));
         step(1);
      end
      rst = 1'b0; idle(); step(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
